// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side inputs and register-file write port of the writeback stage
interface wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
);
  logic                 mem_valid;
  logic [4:0]           mem_rd;
  logic                 mem_reg_write;
  logic [1:0]           mem_wb_sel;
  logic [XLEN-1:0]      mem_alu_result;
  logic [XLEN-1:0]      mem_pc_plus4;
  logic [2:0]           mem_funct3;
  logic [XLEN-1:0]      mem_rdata;
  logic                 stall;
  logic                 flush;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_rd_din;
  logic                 wb_reg_write;
  logic                 wb_misalign;
  logic [CNT_WIDTH-1:0] instret;
  modport master (
    output mem_valid, mem_rd, mem_reg_write, mem_wb_sel, mem_alu_result,
           mem_pc_plus4, mem_funct3, mem_rdata, stall, flush,
    input  wb_rd, wb_rd_din, wb_reg_write, wb_misalign, instret
  );
  modport slave (
    input  mem_valid, mem_rd, mem_reg_write, mem_wb_sel, mem_alu_result,
           mem_pc_plus4, mem_funct3, mem_rdata, stall, flush,
    output wb_rd, wb_rd_din, wb_reg_write, wb_misalign, instret
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load alignment/extension and retired-instruction counter
module wb_stage #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
  wb_stage_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  logic                 valid_q;
  logic [4:0]           rd_q;
  logic                 regwrite_q;
  logic [1:0]           sel_q;
  logic [XLEN-1:0]      alu_q;
  logic [XLEN-1:0]      pc4_q;
  logic [2:0]           funct3_q;
  logic [XLEN-1:0]      rdata_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [1:0]           off;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [XLEN-1:0]      load_data;
  logic                 misaligned;
  logic                 illegal;
  logic                 misalign;
  logic                 reg_write;
  // MEM/WB latch: flush beats stall; fields other than valid are left alone on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      sel_q      <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      funct3_q   <= '0;
      rdata_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q    <= bus.mem_valid;
      rd_q       <= bus.mem_rd;
      regwrite_q <= bus.mem_reg_write;
      sel_q      <= bus.mem_wb_sel;
      alu_q      <= bus.mem_alu_result;
      pc4_q      <= bus.mem_pc_plus4;
      funct3_q   <= bus.mem_funct3;
      rdata_q    <= bus.mem_rdata;
    end
  end
  // retired count advances only when a real instruction enters the latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else if (!bus.flush && !bus.stall && bus.mem_valid) instret_q <= instret_q + CNT_ONE;
  end
  assign off     = alu_q[1:0];
  assign ld_byte = rdata_q[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? rdata_q[16 +: 16] : rdata_q[0 +: 16];
  // extend the addressed byte/halfword and classify the load format
  always_comb begin
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3_q)
      3'b000: load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        load_data  = {{(XLEN-16){ld_half[15]}}, ld_half};
        misaligned = off[0];
      end
      3'b101: begin
        load_data  = {{(XLEN-16){1'b0}}, ld_half};
        misaligned = off[0];
      end
      3'b010: begin
        load_data  = rdata_q;
        misaligned = off != 2'b00;
      end
      default: illegal = 1'b1;
    endcase
  end
  assign misalign         = valid_q && sel_q == 2'b01 && (misaligned || illegal);
  assign reg_write        = valid_q && regwrite_q && rd_q != 5'd0 && !misalign;
  assign bus.wb_misalign  = misalign;
  assign bus.wb_reg_write = reg_write;
  assign bus.wb_rd        = reg_write ? rd_q : 5'd0;
  assign bus.wb_rd_din    = sel_q == 2'b01 ? load_data : sel_q == 2'b10 ? pc4_q : alu_q;
  assign bus.instret      = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven scoreboard bench for the writeback stage
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cnt = 0;
  wb_stage_if #(.XLEN(32), .CNT_WIDTH(64)) im ();
  wb_stage_if #(.XLEN(32), .CNT_WIDTH(4))  iw ();
  wb_stage #(.XLEN(32), .CNT_WIDTH(64)) dut   (.clk(clk), .rst_n(rst_n), .bus(im));
  wb_stage #(.XLEN(32), .CNT_WIDTH(4))  dut_w (.clk(clk), .rst_n(rst_n), .bus(iw));
  assign iw.mem_valid      = im.mem_valid;
  assign iw.mem_rd         = im.mem_rd;
  assign iw.mem_reg_write  = im.mem_reg_write;
  assign iw.mem_wb_sel     = im.mem_wb_sel;
  assign iw.mem_alu_result = im.mem_alu_result;
  assign iw.mem_pc_plus4   = im.mem_pc_plus4;
  assign iw.mem_funct3     = im.mem_funct3;
  assign iw.mem_rdata      = im.mem_rdata;
  assign iw.stall          = im.stall;
  assign iw.flush          = im.flush;
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [4:0]  e_rd;
    logic [31:0] e_din;
    logic        e_rw;
    logic        e_mis;
    logic        chk_din;
  } vec_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] din;
    logic        rw;
    logic        mis;
    logic        chk_din;
    int          cnt;
  } exp_t;
  vec_t vecs[15];
  exp_t sb[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    im.mem_valid      = v;
    im.mem_rd         = rd;
    im.mem_reg_write  = rw;
    im.mem_wb_sel     = sel;
    im.mem_alu_result = alu;
    im.mem_pc_plus4   = pc4;
    im.mem_funct3     = f3;
    im.mem_rdata      = 32'h80FF_7F01;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t e;
    logic [4:0]  h_rd;
    logic [31:0] h_din;
    vecs[0]  = '{1, 5'd5, 1, 2'b00, 32'h1234_5678, 32'h0, 3'b000, 5'd5, 32'h1234_5678, 1, 0, 1};
    vecs[1]  = '{1, 5'd6, 1, 2'b01, 32'h0000_1003, 32'h0, 3'b000, 5'd6, 32'hFFFF_FF80, 1, 0, 1};
    vecs[2]  = '{1, 5'd6, 1, 2'b01, 32'h0000_1003, 32'h0, 3'b100, 5'd6, 32'h0000_0080, 1, 0, 1};
    vecs[3]  = '{1, 5'd7, 1, 2'b01, 32'h0000_1002, 32'h0, 3'b001, 5'd7, 32'hFFFF_80FF, 1, 0, 1};
    vecs[4]  = '{1, 5'd8, 1, 2'b01, 32'h0000_1000, 32'h0, 3'b101, 5'd8, 32'h0000_7F01, 1, 0, 1};
    vecs[5]  = '{1, 5'd9, 1, 2'b01, 32'h0000_1000, 32'h0, 3'b010, 5'd9, 32'h80FF_7F01, 1, 0, 1};
    vecs[6]  = '{1, 5'd9, 1, 2'b01, 32'h0000_1002, 32'h0, 3'b010, 5'd0, 32'h80FF_7F01, 0, 1, 1};
    vecs[7]  = '{1, 5'd9, 1, 2'b01, 32'h0000_1001, 32'h0, 3'b001, 5'd0, 32'h0, 0, 1, 0};
    vecs[8]  = '{1, 5'd9, 1, 2'b01, 32'h0000_1000, 32'h0, 3'b011, 5'd0, 32'h0, 0, 1, 0};
    vecs[9]  = '{1, 5'd0, 1, 2'b00, 32'h0000_DEAD, 32'h0, 3'b000, 5'd0, 32'h0000_DEAD, 0, 0, 1};
    vecs[10] = '{1, 5'd1, 1, 2'b10, 32'h0000_0F00, 32'h0000_0104, 3'b000, 5'd1, 32'h0000_0104, 1, 0, 1};
    vecs[11] = '{1, 5'd7, 1, 2'b11, 32'h0000_CAFE, 32'h0000_0104, 3'b000, 5'd7, 32'h0000_CAFE, 1, 0, 1};
    vecs[12] = '{1, 5'd3, 0, 2'b00, 32'h0000_0033, 32'h0, 3'b000, 5'd0, 32'h0000_0033, 0, 0, 1};
    vecs[13] = '{0, 5'd4, 1, 2'b00, 32'h0000_0044, 32'h0, 3'b000, 5'd0, 32'h0, 0, 0, 0};
    vecs[14] = '{1, 5'd2, 1, 2'b00, 32'h0000_1003, 32'h0, 3'b010, 5'd2, 32'h0000_1003, 1, 0, 1};
    rst_n = 1'b0;
    im.stall = 1'b0;
    im.flush = 1'b0;
    drive(1, 5'd31, 1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010);
    step();
    step();
    check("reset_rd", {59'b0, im.wb_rd}, 64'd0);
    check("reset_din", {32'b0, im.wb_rd_din}, 64'd0);
    check("reset_rw", {63'b0, im.wb_reg_write}, 64'd0);
    check("reset_mis", {63'b0, im.wb_misalign}, 64'd0);
    check("reset_instret", im.instret, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].rw, vecs[i].sel, vecs[i].alu, vecs[i].pc4, vecs[i].f3);
      if (vecs[i].v) cnt++;
      sb.push_back('{vecs[i].e_rd, vecs[i].e_din, vecs[i].e_rw, vecs[i].e_mis, vecs[i].chk_din, cnt});
      step();
      e = sb.pop_front();
      check($sformatf("vec%0d_rd", i), {59'b0, im.wb_rd}, {59'b0, e.rd});
      check($sformatf("vec%0d_rw", i), {63'b0, im.wb_reg_write}, {63'b0, e.rw});
      check($sformatf("vec%0d_mis", i), {63'b0, im.wb_misalign}, {63'b0, e.mis});
      if (e.chk_din) check($sformatf("vec%0d_din", i), {32'b0, im.wb_rd_din}, {32'b0, e.din});
      check($sformatf("vec%0d_instret", i), im.instret, 64'(e.cnt));
    end
    drive(1, 5'd12, 1, 2'b00, 32'h0000_0055, 32'h0, 3'b000);
    cnt++;
    step();
    h_rd = im.wb_rd;
    h_din = im.wb_rd_din;
    check("stall_pre_rd", {59'b0, h_rd}, 64'd12);
    im.stall = 1'b1;
    drive(1, 5'd13, 1, 2'b00, 32'h0000_0066, 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_rd", i), {59'b0, im.wb_rd}, 64'd12);
      check($sformatf("stall%0d_din", i), {32'b0, im.wb_rd_din}, 64'h55);
      check($sformatf("stall%0d_rw", i), {63'b0, im.wb_reg_write}, 64'd1);
      check($sformatf("stall%0d_instret", i), im.instret, 64'(cnt));
    end
    im.stall = 1'b0;
    cnt++;
    step();
    check("unstall_rd", {59'b0, im.wb_rd}, 64'd13);
    check("unstall_instret", im.instret, 64'(cnt));
    im.stall = 1'b1;
    im.flush = 1'b1;
    step();
    check("flush_rw", {63'b0, im.wb_reg_write}, 64'd0);
    check("flush_rd", {59'b0, im.wb_rd}, 64'd0);
    check("flush_instret", im.instret, 64'(cnt));
    im.stall = 1'b0;
    im.flush = 1'b0;
    drive(1, 5'd10, 1, 2'b00, 32'h0000_00AA, 32'h0, 3'b000);
    cnt++;
    step();
    check("pre_areset_rw", {63'b0, im.wb_reg_write}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_rw", {63'b0, im.wb_reg_write}, 64'd0);
    check("areset_rd", {59'b0, im.wb_rd}, 64'd0);
    check("areset_din", {32'b0, im.wb_rd_din}, 64'd0);
    check("areset_instret", im.instret, 64'd0);
    cnt = 0;
    im.mem_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_areset_rw", {63'b0, im.wb_reg_write}, 64'd0);
    check("post_areset_instret", im.instret, 64'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 5'd1, 1, 2'b00, 32'(i), 32'h0, 3'b000);
      cnt++;
      step();
      if (i == 14) check("wrap_15", {60'b0, iw.instret}, 64'd15);
    end
    check("wrap_0", {60'b0, iw.instret}, 64'd0);
    check("wrap_wide", im.instret, 64'(cnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback stage of the 5-stage RISC-V core. Latches the MEM-stage result and, one cycle later, presents the destination register, write data and write enable that drive the register file write port. Performs load-data alignment and sign/zero extension, flags misaligned or illegal load formats, and keeps a 64-bit retired-instruction counter.

## Interface
- XLEN, 32, data width; matches the register file width.
- CNT_WIDTH, 64, width of the retired-instruction counter.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_rd  in  5  destination register index.
- mem_reg_write  in  1  instruction writes rd.
- mem_wb_sel  in  2  00 ALU result, 01 load data, 10 PC+4, 11 ALU result.
- mem_alu_result  in  XLEN  ALU result; for loads, the effective address.
- mem_pc_plus4  in  XLEN  link value for jal/jalr.
- mem_funct3  in  3  load format.
- mem_rdata  in  XLEN  raw word from data memory, valid in MEM cycle.
- stall  in  1  hold the MEM/WB latch.
- flush  in  1  invalidate the MEM/WB latch.
- wb_rd  out  5  to register file rd; 0 when not writing.
- wb_rd_din  out  XLEN  to register file rd_din.
- wb_reg_write  out  1  to register file reg_write.
- wb_misalign  out  1  latched load is misaligned or illegal format.
- instret  out  CNT_WIDTH  count of instructions accepted into WB.

## Operation
- Latch fields: valid_q, rd_q, regwrite_q, sel_q, alu_q, pc4_q, funct3_q, rdata_q.
- Each rising edge, in priority order:
  - flush: valid_q <= 0; other fields don't-care.
  - stall: all fields hold.
  - otherwise: load all fields from mem_* inputs.
- Load alignment uses alu_q[1:0] as byte offset off and funct3_q:
  - 000 lb: sign-extend byte rdata_q[8*off+7:8*off].
  - 100 lbu: zero-extend the same byte.
  - 001 lh: sign-extend halfword at off (0 or 2); off[0]=1 is misaligned.
  - 101 lhu: zero-extend the same halfword; same misalignment rule.
  - 010 lw: rdata_q; off!=0 is misaligned.
  - 011, 110, 111: illegal.
- wb_misalign = valid_q & sel_q==01 & (misaligned | illegal).
- wb_rd_din mux on sel_q: 00/11 alu_q, 01 aligned load data, 10 pc4_q.
- wb_reg_write = valid_q & regwrite_q & (rd_q != 0) & ~wb_misalign.
- wb_rd = wb_reg_write ? rd_q : 0.
- instret increments by 1 on an edge where the latch loads with mem_valid=1, stall=0 and flush=0. It wraps from all-ones to 0.
- Stalled cycles re-present the same write. Re-writing the same value to the register file is intended. instret does not increment again.

## Timing
- Reset (asynchronous, rst_n low) clears valid_q, all latch fields and instret to 0.
  - Outputs during reset: wb_rd=0, wb_rd_din=0, wb_reg_write=0, wb_misalign=0, instret=0.
  - Reset asserted mid-operation drops the in-flight instruction; no write is issued afterward.
- Latency:
  - Edge N captures the MEM inputs.
  - wb_* outputs are valid combinationally from the latch during cycle N..N+1.
  - The register file commits at edge N+1.
  - Register-file internal forwarding makes the value readable by ID during cycle N..N+1.
- wb_* outputs are a purely combinational function of latch state. There is no combinational path from mem_* inputs to outputs.
- flush and stall together: flush wins, and the latch becomes a bubble.
- Throughput: one instruction per cycle when stall=0.

## Test plan
- Reset release, then alu instruction: mem_rd=5, sel=00, alu=0x1234_5678, reg_write=1 → one cycle later wb_rd=5, wb_rd_din=0x12345678, wb_reg_write=1; instret=1.
- Load formats with rdata=0x80FF_7F01:
  - lb at off=3 → 0xFFFFFF80.
  - lbu at off=3 → 0x00000080.
  - lh at off=2 → 0xFFFF80FF.
  - lhu at off=0 → 0x00007F01.
  - lw at off=0 → 0x80FF7F01.
- Misalignment: lw with alu=0x1002, and lh with off=1 → wb_misalign=1, wb_reg_write=0, wb_rd=0; funct3=011 behaves the same; instret still increments.
- x0 and jal:
  - rd=0 with reg_write=1 → wb_reg_write=0.
  - sel=10, pc4=0x0000_0104, rd=1 → wb_rd_din=0x104.
- Stall/flush:
  - stall held 3 cycles → outputs constant, instret unchanged.
  - flush with stall=1 → next cycle wb_reg_write=0.
  - mem_valid=0 → no write, instret unchanged.
- Async reset asserted mid-cycle while wb_reg_write=1 → outputs drop to 0 immediately, without waiting for a clock edge.
- Counter wrap with CNT_WIDTH=4: 16 valid instructions → instret returns to 0.
